slow_clk_period_meter: RTL and testbench

//  Measures the period and high time of a slow square wave (e.g. the 80 Hz motor/sensor tick) in clk_256kHz cycles.

---
 rtl/slow_clk_period_meter.sv | 151 +++++++++++++++
 tb/tb_slow_clk_period_meter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_period_meter.sv
// Measures period and high time of a slow, asynchronous square wave in clk_256kHz cycles.
// Optional period-lock detector is compiled in when PERIOD_LOCK_EN is defined.
module slow_clk_period_meter #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 12800,
    parameter int EXP_PERIOD = 3200,
    parameter int TOL        = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_256kHz,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout_out,
    output logic             locked
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, TIMED_OUT} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       sync_reg;
    logic             rise, fall;
    logic             arm, take_meas, go_timeout;
    logic [CNT_W-1:0] per_cnt_reg, hi_cnt_reg, hi_lat_reg;
    logic [CNT_W-1:0] period_reg, high_reg;
    logic             valid_reg, timeout_reg;

    // sync_reg[0..1] form the synchronizer, sync_reg[2] is the edge-detect delay
    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset)
            sync_reg <= '0;
        else
            sync_reg <= {sync_reg[1:0], sig_in};
    end

    assign rise = sync_reg[1] & ~sync_reg[2];
    assign fall = ~sync_reg[1] & sync_reg[2];

    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset)
            state_reg <= WAIT_FIRST;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        arm        = 1'b0;
        take_meas  = 1'b0;
        go_timeout = 1'b0;
        case (state_reg)
            WAIT_FIRST: begin
                if (rise) begin
                    arm        = 1'b1;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                // a rise on the last allowed cycle still counts as a measurement
                if (rise) begin
                    take_meas = 1'b1;
                end else if (per_cnt_reg == TO_LAST) begin
                    go_timeout = 1'b1;
                    state_next = TIMED_OUT;
                end
            end
            TIMED_OUT: begin
                if (rise) begin
                    arm        = 1'b1;
                    state_next = MEASURE;
                end
            end
            default: state_next = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset) begin
            per_cnt_reg <= '0;
            hi_cnt_reg  <= '0;
            hi_lat_reg  <= '0;
            period_reg  <= '0;
            high_reg    <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            valid_reg <= take_meas;
            if (arm || take_meas) begin
                per_cnt_reg <= '0;
                hi_cnt_reg  <= '0;
            end else if (state_reg == MEASURE) begin
                per_cnt_reg <= per_cnt_reg + 1'b1;
                hi_cnt_reg  <= hi_cnt_reg + 1'b1;
            end
            if (state_reg == MEASURE && fall)
                hi_lat_reg <= hi_cnt_reg + 1'b1;
            if (take_meas) begin
                period_reg <= per_cnt_reg + 1'b1;
                high_reg   <= hi_lat_reg;
            end
            if (go_timeout)
                timeout_reg <= 1'b1;
            else if (arm)
                timeout_reg <= 1'b0;
        end
    end

    assign period_out  = period_reg;
    assign high_out    = high_reg;
    assign valid       = valid_reg;
    assign timeout_out = timeout_reg;

`ifdef PERIOD_LOCK_EN
    localparam int               SW     = $clog2(LOCK_COUNT + 1);
    localparam logic [SW-1:0]    LOCK_N = SW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);

    logic [CNT_W-1:0] period_new, period_diff;
    logic             in_tol;
    logic [SW-1:0]    streak_reg, streak_next;
    logic             locked_reg;

    assign period_new  = per_cnt_reg + 1'b1;
    assign period_diff = (period_new >= EXP_P) ? (period_new - EXP_P) : (EXP_P - period_new);
    assign in_tol      = (period_diff <= TOL_V);
    assign streak_next = (streak_reg < LOCK_N) ? streak_reg + 1'b1 : streak_reg;

    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset) begin
            streak_reg <= '0;
            locked_reg <= 1'b0;
        end else if (go_timeout || (take_meas && !in_tol)) begin
            streak_reg <= '0;
            locked_reg <= 1'b0;
        end else if (take_meas) begin
            streak_reg <= streak_next;
            locked_reg <= (streak_next == LOCK_N);
        end
    end

    assign locked = locked_reg;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clk_period_meter.sv
// Randomized scoreboard bench for slow_clk_period_meter; expectations come from rise/fall times of the driven wave.
`timescale 1ns/1ps
module tb_slow_clk_period_meter;

    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 12800;
    localparam int EXP_PERIOD = 3200;
    localparam int TOL        = 16;
    localparam int LOCK_COUNT = 4;

    logic             clk_256kHz = 1'b0;
    logic             reset      = 1'b1;
    logic             sig_in     = 1'b0;
    logic [CNT_W-1:0] period_out, high_out;
    logic             valid, timeout_out, locked;

    slow_clk_period_meter #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .EXP_PERIOD(EXP_PERIOD),
        .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk_256kHz (clk_256kHz),
        .reset      (reset),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout_out(timeout_out),
        .locked     (locked)
    );

    always #5 clk_256kHz = ~clk_256kHz;

    int cyc = 0;
    always @(posedge clk_256kHz) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int at_cyc;
        int period;
        int high;
        int lck;
    } exp_t;
    exp_t exp_q[$];

    // reference model state: what has happened to sig_in so far
    bit armed      = 0;
    int prev_rise  = 0;
    int last_high  = 0;
    int streak     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // a rise driven at the negedge after edge c is acted on by the DUT at edge c+3
    task automatic on_rise(input int c);
        int gap;
        int lk;
        if (armed) begin
            gap = c - prev_rise;
            if (gap <= TIMEOUT) begin
                lk = 0;
`ifdef PERIOD_LOCK_EN
                if ((gap > EXP_PERIOD ? gap - EXP_PERIOD : EXP_PERIOD - gap) <= TOL)
                    streak = (streak < LOCK_COUNT) ? streak + 1 : streak;
                else
                    streak = 0;
                lk = (streak == LOCK_COUNT) ? 1 : 0;
`endif
                exp_q.push_back('{c + 3, gap, last_high, lk});
            end else begin
                streak = 0;
            end
        end
        armed     = 1;
        prev_rise = c;
    endtask

    task automatic drive_wave(input int p, input int h);
        on_rise(cyc);
        sig_in = 1'b1;
        repeat (h) @(negedge clk_256kHz);
        sig_in    = 1'b0;
        last_high = cyc - prev_rise;
        repeat (p - h) @(negedge clk_256kHz);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_period"},  int'(period_out), 0);
        chk({tag, "_high"},    int'(high_out), 0);
        chk({tag, "_valid"},   int'(valid), 0);
        chk({tag, "_timeout"}, int'(timeout_out), 0);
        chk({tag, "_locked"},  int'(locked), 0);
    endtask

    always @(negedge clk_256kHz) begin
        if (!reset && valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_cycle", cyc, e.at_cyc);
                chk("period_out", int'(period_out), e.period);
                chk("high_out", int'(high_out), e.high);
                chk("locked", int'(locked), e.lck);
                chk("timeout_on_valid", int'(timeout_out), 0);
                $display("valid @%0d period=%0d high=%0d locked=%0d", cyc, period_out, high_out, locked);
            end
        end
    end

    initial begin
        int r_last;
        int p;
        int h;

        repeat (4) @(negedge clk_256kHz);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk_256kHz);

        // 80 Hz: first rise only arms, then 3200/1600 each period
        repeat (3) drive_wave(3200, 1600);

        // stall: timeout exactly TIMEOUT cycles after the last rise was acted on
        r_last = prev_rise;
        while (cyc < r_last + 3 + TIMEOUT - 1) @(negedge clk_256kHz);
        chk("timeout_before", int'(timeout_out), 0);
        @(negedge clk_256kHz);
        chk("timeout_at", int'(timeout_out), 1);
        chk("timeout_hold_period", int'(period_out), 3200);
        chk("timeout_hold_high", int'(high_out), 1600);
        chk("timeout_locked", int'(locked), 0);
        repeat (20) @(negedge clk_256kHz);

        // recovery followed by the lock sequence (last period leaves tolerance)
        drive_wave(3200, 1600);
        chk("timeout_cleared", int'(timeout_out), 0);
        drive_wave(3210, 1605);
        drive_wave(3190, 1595);
        drive_wave(3216, 1608);
        drive_wave(3217, 1608);
        drive_wave(1000, 250);

        // 25% duty
        repeat (4) drive_wave(1000, 250);

        // boundary: a rise on the very last cycle before timeout wins
        drive_wave(TIMEOUT, 100);
        drive_wave(1000, 500);
        chk("boundary_no_timeout", int'(timeout_out), 0);

        // reset mid-period with sig_in held high through it
        on_rise(cyc);
        sig_in = 1'b1;
        repeat (300) @(negedge clk_256kHz);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        armed     = 0;
        streak    = 0;
        last_high = 0;
        chk("midreset_queue_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk_256kHz);
        reset = 1'b0;
        on_rise(cyc);
        repeat (200) @(negedge clk_256kHz);
        sig_in    = 1'b0;
        last_high = cyc - prev_rise;
        repeat (500) @(negedge clk_256kHz);
        repeat (3) drive_wave(1000, 400);

        // randomized waves, both phases at least two cycles
        for (int i = 0; i < 16; i++) begin
            p = $urandom_range(1200, 4);
            h = $urandom_range(p - 2, 2);
            drive_wave(p, h);
        end
        drive_wave(100, 50);

        repeat (10) @(negedge clk_256kHz);
        chk("pending_valids", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
